wave_meas: RTL and testbench
============================

# wave_meas

Waveform measurement block: the receiving end of the function generator's 8-bit `signal_waveform` sample stream. It digitises the stream against a programmable threshold with hysteresis, then measures period, high time, and min/max amplitude per cycle. It sits beside the generator in the signal_generator IP, feeding registers readable by the processor, and closes the loop for self-test of SINE/TRIANGLE/SQUARE/PWM output.

## Interface
- `HYST`, 8: hysteresis half-width in sample LSBs.
- `CNT_W`, 32: width of the period and high-time counters.
- `TIMEOUT_CYC`, 1_000_000: clocks without a rising edge before timeout.
- `clk` input 1: single clock; all logic on posedge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `enable` input 1: measurement enable; low forces IDLE.
- `sample_in` input 8: waveform sample, new value possible every clock.
- `threshold` input 8: crossing level.
- `period` output CNT_W: clocks between the last two rising edges.
- `high_time` output CNT_W: clocks with level high within that period.
- `min_val` output 8: minimum sample within that period.
- `max_val` output 8: maximum sample within that period.
- `meas_valid` output 1: one-cycle pulse when the outputs update.
- `timeout` output 1: sticky; no edge seen within TIMEOUT_CYC.

## Operation
- Stage 1: `s_q <= sample_in`.
- Thresholds use 9-bit arithmetic, saturating:
  - `hi_th = min(threshold + HYST, 255)`
  - `lo_th = (threshold > HYST) ? threshold - HYST : 0`
- Stage 2: `level_q` sets when `s_q >= hi_th` and clears when `s_q <= lo_th`; otherwise it holds.
- Event R is the cycle in which `level_q` goes 0→1.
- FSM has three states:
  - IDLE: counters cleared, `level_q` tracks normally, outputs hold. Goes to ARM when `enable` is 1.
  - ARM: waits for R. On R, clears `cnt`/`hcnt`, loads min/max from `s_q`, and goes to MEASURE.
  - MEASURE: each cycle `cnt++`, `hcnt++` if `level_q`, and min/max updated from `s_q`. On R:
    - latch `period = cnt + 1` and `high_time = hcnt + level_q`;
    - latch `min_val`/`max_val` including the current `s_q`;
    - pulse `meas_valid` and clear `timeout`;
    - restart `cnt`/`hcnt` at 0 and reload min/max from `s_q`;
    - stay in MEASURE.
- Timeout: if `cnt` in MEASURE, or the wait counter in ARM, reaches TIMEOUT_CYC−1:
  - set `timeout` and zero `period`/`high_time`;
  - go to ARM; no `meas_valid` pulse.
- `enable` deasserted in any state → IDLE next cycle. A pending measurement is discarded and `timeout` holds.
- A `threshold` change takes effect the next cycle and does not restart measurement.
- Counters never wrap: the TIMEOUT_CYC guard fires before saturation.

## Timing
- Reset values: `period`=0, `high_time`=0, `min_val`=8'hFF, `max_val`=0, `meas_valid`=0, `timeout`=0, `level_q`=0, state IDLE.
- Latency: a `sample_in` crossing in cycle t gives `level_q` change in t+2 (R at t+2).
- Outputs and `meas_valid` are registered and appear at t+3.
- First valid measurement comes at the second R after entering ARM.
- R and timeout in the same cycle: R wins.
- `enable` falling and R in the same cycle: `enable` wins, no pulse.
- Reset mid-measurement clears everything immediately and asynchronously.

## Structure
- `wave_meas_pkg` holds the `meas_state_t` enum (IDLE, ARM, MEASURE) and the default constants for HYST, CNT_W and TIMEOUT_CYC.
- Sub-module `wave_level_det` contains the stage-1 register, the saturating threshold computation, the hysteresis comparator, `level_q` and the R pulse.
- The top level holds the FSM, counters, min/max trackers and output registers.

## Test plan
- Square wave 0↔255, toggling every 5 clocks, threshold 128 → `period`=10, `high_time`=5, `min_val`=0, `max_val`=255, with `meas_valid` every 10 clocks from the second edge.
- PWM levels 128/255, 3 high of 8, threshold 192, HYST 8 → `period`=8, `high_time`=3, `min_val`=128.
- 100-sample sine LUT (0..255), 1 clock per sample, threshold 128, plus ±5 LSB noise → exactly one R per 100 clocks, `period`=100.
- Constant `sample_in`=200 with TIMEOUT_CYC=64 → `timeout`=1 after 64 clocks in ARM, with no `meas_valid`. A square wave then applied → `timeout` clears at the first `meas_valid`.
- `enable` dropped mid-period and reasserted → no pulse until two fresh R events. Async `rst_n` pulse mid-period → all outputs at reset values immediately.
- `threshold`=3, HYST=8 → `lo_th`=0 and `hi_th`=11, with no wrap. `threshold`=250 → `hi_th`=255, so only samples of 255 set the level.

Source files
------------

// File: rtl/wave_meas_pkg.sv
// rtl/wave_meas_pkg.sv - shared state type and default parameters for wave_meas
package wave_meas_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } meas_state_t;

  localparam int HYST_DEF        = 8;
  localparam int CNT_W_DEF       = 32;
  localparam int TIMEOUT_CYC_DEF = 1_000_000;

endpackage

// File: rtl/wave_level_det.sv
// rtl/wave_level_det.sv - sample register, saturating hysteresis comparator, level and rising-edge pulse
module wave_level_det
  import wave_meas_pkg::*;
#(
  parameter int HYST = HYST_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sample_in,
  input  logic [7:0] threshold,
  output logic [7:0] s_q,
  output logic       level_q,
  output logic       rise
);

  logic [8:0] hi_sum;
  logic [7:0] hi_th;
  logic [7:0] lo_th;
  logic       level_d;

  // Both thresholds clamp to the 8-bit range instead of wrapping
  always_comb begin
    hi_sum = {1'b0, threshold} + 9'(HYST);
    hi_th  = hi_sum[8] ? 8'hFF : hi_sum[7:0];
    lo_th  = (threshold > 8'(HYST)) ? threshold - 8'(HYST) : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= 8'h00;
      level_q <= 1'b0;
      level_d <= 1'b0;
    end else begin
      s_q <= sample_in;
      if (s_q >= hi_th) begin
        level_q <= 1'b1;
      end else if (s_q <= lo_th) begin
        level_q <= 1'b0;
      end
      level_d <= level_q;
    end
  end

  assign rise = level_q & ~level_d;

endmodule

// File: rtl/wave_meas.sv
// rtl/wave_meas.sv - per-cycle period, high time and min/max measurement of a digitised sample stream
module wave_meas
  import wave_meas_pkg::*;
#(
  parameter int HYST        = HYST_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [7:0]       sample_in,
  input  logic [7:0]       threshold,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [7:0]       min_val,
  output logic [7:0]       max_val,
  output logic             meas_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

  logic [7:0]       s_q;
  logic             level_q;
  logic             rise;
  meas_state_t      state;
  meas_state_t      state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcnt;
  logic [7:0]       cur_min;
  logic [7:0]       cur_max;
  logic             at_limit;
  logic             active;
  logic             do_clear;
  logic             do_restart;
  logic             do_latch;
  logic             do_timeout;

  wave_level_det #(
    .HYST (HYST)
  ) u_level_det (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample_in (sample_in),
    .threshold (threshold),
    .s_q       (s_q),
    .level_q   (level_q),
    .rise      (rise)
  );

  assign at_limit = (cnt == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (!enable) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    state_nx = ARM;
        ARM:     state_nx = rise ? MEASURE : ARM;
        MEASURE: state_nx = (!rise && at_limit) ? ARM : MEASURE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // An edge always beats a coinciding timeout; a falling enable beats both
  always_comb begin
    active     = enable && ((state == ARM) || (state == MEASURE));
    do_clear   = !active;
    do_restart = active && rise;
    do_latch   = do_restart && (state == MEASURE);
    do_timeout = active && !rise && at_limit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      hcnt    <= '0;
      cur_min <= 8'hFF;
      cur_max <= 8'h00;
    end else if (do_clear || do_timeout) begin
      cnt  <= '0;
      hcnt <= '0;
    end else if (do_restart) begin
      cnt     <= '0;
      hcnt    <= '0;
      cur_min <= s_q;
      cur_max <= s_q;
    end else begin
      cnt <= cnt + CNT_W'(1);
      if (state == MEASURE) begin
        hcnt    <= hcnt + CNT_W'(level_q);
        cur_min <= (s_q < cur_min) ? s_q : cur_min;
        cur_max <= (s_q > cur_max) ? s_q : cur_max;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period     <= '0;
      high_time  <= '0;
      min_val    <= 8'hFF;
      max_val    <= 8'h00;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= do_latch;
      if (do_latch) begin
        period    <= cnt + CNT_W'(1);
        high_time <= hcnt + CNT_W'(level_q);
        min_val   <= (s_q < cur_min) ? s_q : cur_min;
        max_val   <= (s_q > cur_max) ? s_q : cur_max;
        timeout   <= 1'b0;
      end else if (do_timeout) begin
        period    <= '0;
        high_time <= '0;
        timeout   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wave_meas.sv
// tb/tb_wave_meas.sv - self-checking bench for wave_meas
module tb_wave_meas;

  localparam int HYST = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [7:0]  sample_in;
  logic [7:0]  threshold;
  logic [31:0] period, high_time;
  logic [7:0]  min_val, max_val;
  logic        meas_valid, timeout;
  logic [15:0] to_period, to_high_time;
  logic [7:0]  to_min_val, to_max_val;
  logic        to_meas_valid, to_timeout;

  int total = 0;
  int bad = 0;

  int samp [0:4095];
  int lvl  [0:4095];
  bit edg  [0:4095];
  int noise [0:99];

  typedef struct {
    int thr; int hv; int lv; int nh; int nl; int reps;
    int exp_pulses; int exp_period; int exp_high; int exp_min; int exp_max;
  } vec_t;
  vec_t tbl [0:5];

  always #5 clk = ~clk;

  wave_meas #(.HYST(HYST), .CNT_W(32), .TIMEOUT_CYC(5000)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_in(sample_in), .threshold(threshold),
    .period(period), .high_time(high_time), .min_val(min_val), .max_val(max_val),
    .meas_valid(meas_valid), .timeout(timeout)
  );

  wave_meas #(.HYST(HYST), .CNT_W(16), .TIMEOUT_CYC(64)) u_dut_to (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_in(sample_in), .threshold(threshold),
    .period(to_period), .high_time(to_high_time), .min_val(to_min_val), .max_val(to_max_val),
    .meas_valid(to_meas_valid), .timeout(to_timeout)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic en, input int s);
    @(negedge clk);
    enable    = en;
    sample_in = 8'(s);
  endtask

  function automatic int clamp8(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  // Reference: digitise the recorded stream, then measure between consecutive rising edges
  task automatic run_stream(input int n, input int thr_v, output int last_per, output int dut_pulses);
    int hi, lo, l, last_e, e, ep, eh, emn, emx;
    hi = thr_v + HYST; if (hi > 255) hi = 255;
    lo = thr_v - HYST; if (lo < 0) lo = 0;
    for (int k = n; k < n + 4; k++) samp[k] = samp[n-1];
    l = 0;
    for (int k = 0; k < n + 4; k++) begin
      edg[k] = 1'b0;
      if (samp[k] >= hi) begin
        if (l == 0) edg[k] = 1'b1;
        l = 1;
      end else if (samp[k] <= lo) begin
        l = 0;
      end
      lvl[k] = l;
    end
    threshold = 8'(thr_v);
    repeat (4) step(1'b0, 0);
    last_e = -1; last_per = 0; dut_pulses = 0;
    for (int j = 0; j < n + 4; j++) begin
      step(1'b1, samp[j]);
      if (meas_valid) dut_pulses++;
      if (j < 3) begin
        chk("stream_early", meas_valid, 0);
      end else begin
        e = j - 3;
        if (edg[e] && last_e >= 0) begin
          ep = e - last_e; eh = 0; emn = 255; emx = 0;
          for (int k = last_e + 1; k <= e; k++) eh += lvl[k];
          for (int k = last_e + 1; k <= e + 1; k++) begin
            if (samp[k] < emn) emn = samp[k];
            if (samp[k] > emx) emx = samp[k];
          end
          chk("stream_valid", meas_valid, 1);
          chk("stream_period", period, ep);
          chk("stream_high", high_time, eh);
          chk("stream_min", min_val, emn);
          chk("stream_max", max_val, emx);
          last_per = period;
        end else begin
          chk("stream_idle", meas_valid, 0);
        end
        if (edg[e]) last_e = e;
      end
    end
    chk("stream_timeout", timeout, 0);
  endtask

  initial begin
    int lp, np, pulses, first, prev_to, len, v, thr_r;

    tbl[0] = '{128, 255,   0, 5, 5, 4, 3, 10, 5,   0, 255};
    tbl[1] = '{192, 255, 128, 3, 5, 4, 3,  8, 3, 128, 255};
    tbl[2] = '{  3,  11,   0, 4, 6, 4, 3, 10, 4,   0,  11};
    tbl[3] = '{  3,  10,   0, 4, 6, 4, 0,  0, 0,   0,   0};
    tbl[4] = '{250, 255, 240, 2, 6, 4, 3,  8, 2, 240, 255};
    tbl[5] = '{250, 254, 240, 2, 6, 4, 0,  0, 0,   0,   0};

    rst_n = 1'b0; enable = 1'b0; sample_in = 8'h00; threshold = 8'd128;
    repeat (3) @(negedge clk);
    chk("rst_period", period, 0);
    chk("rst_high", high_time, 0);
    chk("rst_min", min_val, 255);
    chk("rst_max", max_val, 0);
    chk("rst_valid", meas_valid, 0);
    chk("rst_timeout", timeout, 0);
    rst_n = 1'b1;

    for (int t = 0; t < 6; t++) begin
      int p, last_j, gap_bad, jj;
      threshold = 8'(tbl[t].thr);
      repeat (4) step(1'b0, tbl[t].lv);
      p = tbl[t].nh + tbl[t].nl; pulses = 0; last_j = -1; gap_bad = 0; jj = 0;
      for (int r = 0; r < tbl[t].reps; r++) begin
        for (int i = 0; i < p; i++) begin
          step(1'b1, (i < tbl[t].nh) ? tbl[t].hv : tbl[t].lv);
          if (meas_valid) begin
            pulses++;
            if (last_j >= 0 && (jj - last_j) != p) gap_bad++;
            last_j = jj;
          end
          jj++;
        end
      end
      chk($sformatf("vec%0d_pulses", t), pulses, tbl[t].exp_pulses);
      if (tbl[t].exp_pulses > 0) begin
        chk($sformatf("vec%0d_period", t), period, tbl[t].exp_period);
        chk($sformatf("vec%0d_high", t), high_time, tbl[t].exp_high);
        chk($sformatf("vec%0d_min", t), min_val, tbl[t].exp_min);
        chk($sformatf("vec%0d_max", t), max_val, tbl[t].exp_max);
        chk($sformatf("vec%0d_gap", t), gap_bad, 0);
      end
    end

    // Enable drops in the same cycle as the third edge, then returns
    threshold = 8'd128;
    repeat (4) step(1'b0, 0);
    for (int j = 0; j < 50; j++) begin
      step(!(j >= 22 && j <= 24), ((j % 10) < 5) ? 255 : 0);
      chk($sformatf("en_valid_%0d", j), meas_valid, (j == 13 || j == 43) ? 1 : 0);
      if (j == 43) chk("en_period", period, 10);
    end

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_period", period, 0);
    chk("arst_high", high_time, 0);
    chk("arst_min", min_val, 255);
    chk("arst_max", max_val, 0);
    chk("arst_valid", meas_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    threshold = 8'd128;
    repeat (4) step(1'b0, 200);
    pulses = 0;
    for (int j = 0; j < 66; j++) begin
      step(1'b1, 200);
      if (to_meas_valid) pulses++;
      if (j == 64) chk("to_not_yet", to_timeout, 0);
      if (j == 65) chk("to_set", to_timeout, 1);
    end
    chk("to_no_valid", pulses, 0);
    chk("to_period_zero", to_period, 0);
    first = -1; prev_to = to_timeout;
    for (int k = 0; k < 40; k++) begin
      step(1'b1, ((k % 10) < 5) ? 0 : 255);
      if (to_meas_valid && first < 0) begin
        first = k;
        chk("to_cleared", to_timeout, 0);
        chk("to_held_before", prev_to, 1);
        chk("to_period", to_period, 10);
      end
      prev_to = to_timeout;
    end
    chk("to_first_pulse", first, 18);

    for (int i = 0; i < 100; i++) noise[i] = int'($urandom_range(10)) - 5;
    for (int i = 0; i < 400; i++) begin
      real x;
      x = 128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * real'(i % 100) / 100.0);
      samp[i] = clamp8($rtoi(x + 0.5) + noise[i % 100]);
    end
    run_stream(400, 128, lp, np);
    chk("sine_period", lp, 100);
    chk("sine_pulses", np, 3);

    for (int run = 0; run < 3; run++) begin
      int k;
      thr_r = (run == 0) ? 3 : ((run == 1) ? 250 : 20 + int'($urandom_range(215)));
      k = 0;
      while (k < 1200) begin
        int mode;
        len = 1 + int'($urandom_range(19));
        mode = int'($urandom_range(2));
        v = int'($urandom_range(255));
        for (int i = 0; i < len && k < 1200; i++) begin
          if (mode == 0)
            samp[k] = ($urandom_range(3) == 0) ? (($urandom_range(1) == 1) ? 255 : 0) : int'($urandom_range(255));
          else if (mode == 1)
            samp[k] = clamp8(thr_r - 7 + int'($urandom_range(14)));
          else
            samp[k] = v;
          k++;
        end
      end
      run_stream(1200, thr_r, lp, np);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
